// File: rtl/cbadc_estimate_sink.sv
// rtl/cbadc_estimate_sink.sv - samples the decimated estimate at a fixed phase into a FWFT stream FIFO.
// Optional saturating drop counter: define CBADC_SINK_DROP_COUNT_EN.
module cbadc_estimate_sink #(
  parameter int OSR           = 12,
  parameter int OUT_WIDTH     = 14,
  parameter int CAPTURE_PHASE = 6,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [OUT_WIDTH-1:0]          est_in,
  input  logic                          est_valid,
  output logic [OUT_WIDTH-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);
  localparam int PW = $clog2(OSR);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t               state;
  logic [PW-1:0]        phase;
  logic                 est_valid_d;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  logic                 at_capture;
  logic                 capture;
  logic                 full;
  logic                 pop;
  logic                 wr_en;
  logic                 drop;
  logic [AW-1:0]        rd_ptr_nxt;
  logic [AW:0]          level_nxt;
  logic [OUT_WIDTH-1:0] wdata;

  always_comb begin
    at_capture = (phase == PW'(CAPTURE_PHASE));
    // A low est_valid in the capture cycle suppresses the capture as the FSM drops to IDLE.
    capture    = (state != IDLE) && est_valid && at_capture;
    full       = (level == FULL_LEVEL);
    pop        = m_valid && m_ready;
    wr_en      = capture && (!full || pop);
    drop       = capture && full && !pop;
    wdata      = {~est_in[OUT_WIDTH-1], est_in[OUT_WIDTH-2:0]};
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt  = level;
    if (wr_en && !pop) begin
      level_nxt = level + 1'b1;
    end else if (pop && !wr_en) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      est_valid_d <= 1'b0;
    end else begin
      est_valid_d <= est_valid;
      case (state)
        IDLE: begin
          if (est_valid && !est_valid_d) begin
            state <= ALIGN;
            phase <= PW'(1);
          end
        end
        default: begin
          if (!est_valid) begin
            state <= IDLE;
            phase <= '0;
          end else begin
            phase <= (phase == PW'(OSR-1)) ? '0 : phase + 1'b1;
            if (state == ALIGN && at_capture) state <= RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr  <= rd_ptr_nxt;
      level   <= level_nxt;
      m_valid <= (level_nxt != '0);
      // Next head bypasses memory when it is the slot being written this edge.
      if (level_nxt != '0) begin
        m_data <= (wr_en && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
      end
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef CBADC_SINK_DROP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule
